// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encodings and limits for the serial word link
package serial_pkg;

  localparam int ST_W      = 2;
  localparam int MAX_WIDTH = 32;

  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_SEND = 2'b01;
  localparam logic [ST_W-1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-in, MSB-first serial-out word transmitter
// Optional even-parity trailer bit: SERIAL_WORD_TX_PARITY_EN
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_last,
  output logic             done
);

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SW - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            tx_valid_q, tx_valid_d;
  logic            tx_bit_q, tx_bit_d;
  logic            tx_last_q, tx_last_d;
  logic            done_q, done_d;
  logic [SW-1:0]   load_val;

`ifdef SERIAL_WORD_TX_PARITY_EN
  assign load_val = {in_data, ^in_data};
`else
  assign load_val = in_data;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = ST_SEND;
          shift_d = load_val;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          shift_d = shift_q << 1;
          if (cnt_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        // Illegal code recovers to IDLE with every output at its reset value.
        state_d = ST_IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE) && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    tx_valid_d = (state_d == ST_SEND);
    tx_bit_d   = tx_valid_d && shift_d[SW-1];
    tx_last_d  = tx_valid_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_bit_q   <= 1'b0;
      tx_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_bit_q   <= tx_bit_d;
      tx_last_q  <= tx_last_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_bit   = tx_bit_q;
  assign tx_last  = tx_last_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - randomized self-checking bench for serial_word_tx
module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LEN8 = 8 + PAR;
  localparam int LEN1 = 1 + PAR;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, tx_ready8 = 1'b0;
  logic [7:0] in_data8 = 8'h00;
  logic       in_ready8, tx_valid8, tx_bit8, tx_last8, done8;
  logic       in_valid1 = 1'b0, tx_ready1 = 1'b0;
  logic [0:0] in_data1 = 1'b0;
  logic       in_ready1, tx_valid1, tx_bit1, tx_last1, done1;

  serial_word_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .tx_ready(tx_ready8), .tx_valid(tx_valid8), .tx_bit(tx_bit8), .tx_last(tx_last8), .done(done8)
  );

  serial_word_tx #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .tx_ready(tx_ready1), .tx_valid(tx_valid1), .tx_bit(tx_bit1), .tx_last(tx_last1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  logic exp_bits[$];
  logic obs_bits[$];
  logic obs_last[$];
  int   vcyc, stall_bad, busy_ready, timeout;
  logic first_valid, done_now, ready_now, done_after, ready_after;

  // Reference frame: word bits MSB first, then the even-parity bit when enabled.
  task automatic build_exp(input logic [31:0] w, input int width);
    exp_bits.delete();
    for (int i = width - 1; i >= 0; i--) exp_bits.push_back(w[i]);
    if (PAR == 1) begin
      logic p;
      p = 1'b0;
      for (int i = 0; i < width; i++) p = p ^ w[i];
      exp_bits.push_back(p);
    end
  endtask

  function automatic int bit_mismatches();
    int m;
    m = 0;
    if (obs_bits.size() != exp_bits.size()) return 1000;
    foreach (exp_bits[i]) if (obs_bits[i] !== exp_bits[i]) m++;
    return m;
  endfunction

  function automatic int last_mismatches();
    int m;
    m = 0;
    foreach (obs_last[i]) if (obs_last[i] !== (i == obs_last.size() - 1)) m++;
    return m;
  endfunction

  // mode 0: always ready, 1: stall on tx_valid cycles 2 and 5, 2: random stalls
  task automatic drive8(input logic [7:0] w, input int mode, input bit busy);
    int   k, c;
    logic rdy, stalled, pbit, plast;
    obs_bits.delete();
    obs_last.delete();
    vcyc = 0; stall_bad = 0; busy_ready = 0; timeout = 0;
    stalled = 1'b0; pbit = 1'b0; plast = 1'b0;
    k = 0;
    while (!in_ready8 && k < 50) begin @(negedge clk); k++; end
    if (k == 50) timeout = 1;
    in_valid8 = 1'b1;
    in_data8  = w;
    tx_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    in_data8  = 8'($urandom);
    first_valid = tx_valid8;
    c = 0;
    while (tx_valid8 && c < 100) begin
      c++;
      vcyc++;
      if (in_ready8) busy_ready++;
      if (stalled && (tx_bit8 !== pbit || tx_last8 !== plast)) stall_bad++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(c == 2 || c == 5);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (rdy) begin
        obs_bits.push_back(tx_bit8);
        obs_last.push_back(tx_last8);
      end
      stalled = !rdy; pbit = tx_bit8; plast = tx_last8;
      tx_ready8 = rdy;
      in_valid8 = busy && (c == 3);
      in_data8  = 8'hFF;
      @(negedge clk);
    end
    if (c == 100) timeout = 1;
    in_valid8 = 1'b0;
    done_now  = done8;
    ready_now = in_ready8;
    @(negedge clk);
    done_after  = done8;
    ready_after = in_ready8;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready8, tx_valid8, tx_bit8, tx_last8, done8} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {in_ready8, tx_valid8, tx_bit8, tx_last8, done8});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b want 0", in_ready8); end
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b%b want 11", in_ready8, in_ready1);
    end
  endtask

  task automatic test_basic();
    build_exp(32'hA5, 8);
    drive8(8'hA5, 0, 1'b0);
    checks++;
    if (timeout != 0) begin errors++; $display("FAIL basic_timeout: got %0d want 0", timeout); end
    checks++;
    if (first_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", first_valid); end
    checks++;
    if (bit_mismatches() != 0) begin errors++; $display("FAIL basic_bits: got %0d mismatches want 0", bit_mismatches()); end
    checks++;
    if (last_mismatches() != 0) begin errors++; $display("FAIL basic_last: got %0d mismatches want 0", last_mismatches()); end
    checks++;
    if (vcyc != LEN8) begin errors++; $display("FAIL basic_valid_cycles: got %0d want %0d", vcyc, LEN8); end
    checks++;
    if ({done_now, ready_now, done_after, ready_after} !== 4'b1001) begin
      errors++; $display("FAIL basic_done_ready: got %b want 1001", {done_now, ready_now, done_after, ready_after});
    end
  endtask

  task automatic test_backpressure();
    build_exp(32'h3C, 8);
    drive8(8'h3C, 1, 1'b0);
    checks++;
    if (bit_mismatches() != 0 || timeout != 0) begin
      errors++; $display("FAIL bp_bits: got %0d mismatches timeout %0d want 0", bit_mismatches(), timeout);
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d changes during stall want 0", stall_bad); end
    checks++;
    if (vcyc != LEN8 + 2) begin errors++; $display("FAIL bp_valid_cycles: got %0d want %0d", vcyc, LEN8 + 2); end
    checks++;
    if (last_mismatches() != 0) begin errors++; $display("FAIL bp_last: got %0d mismatches want 0", last_mismatches()); end
  endtask

  task automatic test_busy_ignore();
    int quiet;
    build_exp(32'h5A, 8);
    drive8(8'h5A, 0, 1'b1);
    checks++;
    if (bit_mismatches() != 0 || vcyc != LEN8) begin
      errors++; $display("FAIL busy_bits: got %0d mismatches %0d cycles want 0 and %0d", bit_mismatches(), vcyc, LEN8);
    end
    checks++;
    if (busy_ready != 0 || ready_now !== 1'b0) begin
      errors++; $display("FAIL busy_ready: got %0d ready cycles want 0", busy_ready + int'(ready_now));
    end
    quiet = 0;
    repeat (5) begin @(negedge clk); if (tx_valid8) quiet++; end
    checks++;
    if (quiet != 0) begin errors++; $display("FAIL busy_no_capture: got %0d valid cycles want 0", quiet); end
  endtask

  task automatic test_reset_mid();
    int k, seen;
    k = 0;
    while (!in_ready8 && k < 50) begin @(negedge clk); k++; end
    in_valid8 = 1'b1; in_data8 = 8'hA5; tx_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid8 !== 1'b1 || tx_bit8 !== 1'b0) begin
      errors++; $display("FAIL mid_fourth_bit: got v%b b%b want v1 b0", tx_valid8, tx_bit8);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready8, tx_valid8, tx_bit8, tx_last8, done8} !== 5'b0) begin
      errors++; $display("FAIL mid_async_reset: got %b want 00000", {in_ready8, tx_valid8, tx_bit8, tx_last8, done8});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL mid_ready_release: got %b want 1", in_ready8); end
    seen = 0;
    repeat (6) begin if (tx_valid8) seen++; @(negedge clk); end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_no_resume: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_random();
    logic [7:0] w;
    for (int f = 0; f < 8; f++) begin
      w = 8'($urandom);
      build_exp({24'h0, w}, 8);
      drive8(w, 2, 1'b0);
      checks++;
      if (bit_mismatches() != 0 || last_mismatches() != 0 || stall_bad != 0 || timeout != 0) begin
        errors++;
        $display("FAIL random_frame %02h: got bits %0d last %0d hold %0d timeout %0d want all 0",
                 w, bit_mismatches(), last_mismatches(), stall_bad, timeout);
      end
    end
  endtask

  task automatic test_parity();
`ifdef SERIAL_WORD_TX_PARITY_EN
    build_exp(32'h07, 8);
    drive8(8'h07, 0, 1'b0);
    checks++;
    if (bit_mismatches() != 0 || obs_bits.size() != 9 || obs_bits[8] !== 1'b1 || last_mismatches() != 0) begin
      errors++; $display("FAIL parity_07: got %0d beats %0d mismatches want 9 beats parity 1", obs_bits.size(), bit_mismatches());
    end
    build_exp(32'h03, 8);
    drive8(8'h03, 0, 1'b0);
    checks++;
    if (bit_mismatches() != 0 || obs_bits.size() != 9 || obs_bits[8] !== 1'b0) begin
      errors++; $display("FAIL parity_03: got %0d beats %0d mismatches want 9 beats parity 0", obs_bits.size(), bit_mismatches());
    end
`else
    build_exp(32'h07, 8);
    drive8(8'h07, 0, 1'b0);
    checks++;
    if (bit_mismatches() != 0 || obs_bits.size() != 8) begin
      errors++; $display("FAIL no_parity_07: got %0d beats %0d mismatches want 8 beats", obs_bits.size(), bit_mismatches());
    end
`endif
  endtask

  task automatic test_width1();
    int acc[$];
    int bad_bits, bad_last, bad_gap, ndone, nbeats;
    bad_bits = 0; bad_last = 0; bad_gap = 0; ndone = 0; nbeats = 0;
    build_exp(32'h1, 1);
    in_data1 = 1'b1; in_valid1 = 1'b1; tx_ready1 = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (in_ready1 && in_valid1) acc.push_back(cyc);
      if (tx_valid1) begin
        if (tx_bit1 !== exp_bits[nbeats % LEN1]) bad_bits++;
        if (tx_last1 !== ((nbeats % LEN1) == LEN1 - 1)) bad_last++;
        nbeats++;
      end
      if (done1) ndone++;
    end
    in_valid1 = 1'b0;
    for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != LEN1 + 2) bad_gap++;
    checks++;
    if (acc.size() < 5 || bad_gap != 0) begin
      errors++; $display("FAIL w1_spacing: got %0d accepts %0d bad gaps want gap %0d", acc.size(), bad_gap, LEN1 + 2);
    end
    checks++;
    if (bad_bits != 0 || bad_last != 0 || nbeats < LEN1) begin
      errors++; $display("FAIL w1_beats: got bits %0d last %0d beats %0d want 0 0", bad_bits, bad_last, nbeats);
    end
    checks++;
    if (ndone < acc.size() - 1 || ndone > acc.size()) begin
      errors++; $display("FAIL w1_done: got %0d done pulses for %0d accepts", ndone, acc.size());
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_ignore();
    test_parity();
    test_random();
    test_width1();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-in, serial-out word transmitter.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per accepted beat, over a bit-level valid/ready link.
- Serves as the sending end of the bitwise equality checkers in the exercise set. A downstream receiver/comparator consumes tx_bit and compares it against its expected bit.

Parameters:
- WIDTH, 8, data word width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a word on in_data.
- in_data  input  WIDTH  word to transmit.
- in_ready  output  1  block can accept a word this cycle.
- tx_ready  input  1  downstream accepts tx_bit this cycle.
- tx_valid  output  1  tx_bit is valid.
- tx_bit  output  1  current serial bit.
- tx_last  output  1  current bit is the final bit of the frame.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset (async, active-high): state=IDLE, shift register=0, bit counter=0, in_ready=0, tx_valid=0, tx_bit=0, tx_last=0, done=0. in_ready rises on the first clock edge after reset deasserts. Reset asserted mid-frame aborts the frame immediately; the partial frame is not resumed.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State IDLE:
  - in_ready=1, tx_valid=0.
  - in_valid&&in_ready at edge N latches in_data into the shift register and loads counter=WIDTH-1 (WIDTH with PARITY_EN).
  - Next state SEND; in_ready=0 and tx_valid=1 from cycle N+1. First-bit latency is 1 cycle.
- State SEND:
  - tx_valid=1, tx_bit=shift register MSB.
  - A beat is accepted on an edge with tx_valid&&tx_ready; each accepted beat shifts left by 1 (zero-fill) and decrements the counter.
  - tx_ready=0 stalls: tx_bit, tx_last and the counter hold, for any number of cycles.
  - tx_last=1 exactly when counter==0.
  - The beat accepted with tx_last=1 sends the block to DONE; tx_valid and tx_last drop on that edge.
  - in_valid is ignored; in_ready stays 0.
- State DONE:
  - done=1 for exactly one cycle, in_ready=0, tx_valid=0.
  - Next state is always IDLE.
  - Minimum spacing between consecutive word accepts is WIDTH+2 cycles when tx_ready is held high.
- WIDTH=1: the single bit is sent with tx_last=1 on its first beat.
- Counter width is clog2(WIDTH+1); the counter never wraps below 0.
- State encoding: IDLE=2'b00, SEND=2'b01, DONE=2'b10. The unused code 2'b11 returns to IDLE on the next edge with all outputs at reset values.

Optional Feature:
- SERIAL_WORD_TX_PARITY_EN.
- When defined: after the WIDTH data bits, one extra even-parity bit (XOR-reduction of the latched word) is sent. tx_last is asserted on the parity bit, not on data bit 0. Frame length is WIDTH+1 beats and the counter loads WIDTH.
- When undefined: the frame is WIDTH beats and no parity logic is present.

Decomposition:
- Shared package serial_pkg holds the state encodings (ST_IDLE, ST_SEND, ST_DONE), the 2-bit state width constant, and MAX_WIDTH=32. The matching receiver imports the same package.
- No sub-module: the shift register, counter and FSM form a single always-block datapath, and parity is a single reduction XOR.

Test Plan:
- Reset mid-frame: WIDTH=8, send 8'hA5 and assert reset after 3 accepted bits -> all outputs 0 at once; in_ready=1 on the first edge after release; no further tx_valid.
- Basic frame: WIDTH=8, tx_ready=1, send 8'hA5 -> tx_bit sequence 1,0,1,0,0,1,0,1 on consecutive cycles, first bit one cycle after accept, tx_last only on the 8th bit, done pulse on the next cycle, in_ready=1 the cycle after that.
- Backpressure: send 8'h3C with tx_ready low on the 2nd and 5th bit cycles -> bit and tx_last held during stalls; sequence still 0,0,1,1,1,1,0,0; total 10 tx_valid cycles.
- Input ignored while busy: pulse in_valid with in_data=8'hFF during SEND -> not captured; only the original frame appears; in_ready stays 0 until after done.
- WIDTH=1 edge case: send 1'b1 -> one beat with tx_bit=1 and tx_last=1, then done; back-to-back words accepted 3 cycles apart.
- With SERIAL_WORD_TX_PARITY_EN: send 8'h07 -> 9 beats 0,0,0,0,0,1,1,1,1 (parity 1); tx_last on the 9th beat. Send 8'h03 -> parity bit 0.
